// File: rtl/main_memory_if.sv
// Request/response bundle between a cache controller and main_memory.
// One request outstanding at a time; valid/ready on requests, single-cycle response pulse.
interface main_memory_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_store;
  logic [LINE_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_store, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_store, resp_data
  );

  modport slave (
    input  req_valid, req_store, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_store, resp_data
  );
endinterface

// File: rtl/main_memory.sv
// Behavioural byte-flop main memory: byte/half/word stores, full-line reads; response LATENCY cycles after accept.
// Backpressure: req_ready only in IDLE, so a single request is in flight; responses cannot be stalled.
module main_memory #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 5
) (
  input logic          clk,
  input logic          reset_n,
  main_memory_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int LB = LINE_WIDTH / 8;
  localparam int OB = $clog2(LB);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [7:0]            r_mem [DEPTH_BYTES];
  logic [LINE_WIDTH-1:0] r_line;
  logic                  r_store;

  logic                  w_accept;
  logic [AW-1:0]         w_ea;
  logic [AW-1:0]         w_line_base;
  logic [AW-1:0]         w_st_base;
  logic [3:0]            w_be;
  logic                  w_unused;

  assign w_accept    = bus.req_valid && (r_state == S_IDLE);
  assign w_ea        = bus.req_addr[AW-1:0];
  assign w_line_base = {w_ea[AW-1:OB], {OB{1'b0}}};
  assign w_unused    = ^bus.req_addr[ADDR_WIDTH-1:AW];

  // Misaligned half/word stores are silently aligned down.
  always_comb begin
    w_st_base = w_ea;
    w_be      = 4'b0001;
    case (bus.req_size)
      2'b00: begin
        w_st_base = w_ea;
        w_be      = 4'b0001;
      end
      2'b01: begin
        w_st_base = {w_ea[AW-1:1], 1'b0};
        w_be      = 4'b0011;
      end
      default: begin
        w_st_base = {w_ea[AW-1:2], 2'b00};
        w_be      = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == CW'(1)) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= CW'(LATENCY - 1);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Reads snapshot the line at accept, so later stores cannot disturb a pending response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH_BYTES; i++) r_mem[i] <= '0;
      r_line  <= '0;
      r_store <= 1'b0;
    end else if (w_accept) begin
      r_store <= bus.req_store;
      if (bus.req_store) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_st_base + AW'(b)] <= bus.req_wdata[8*b +: 8];
        end
      end else begin
        for (int i = 0; i < LB; i++) r_line[8*i +: 8] <= r_mem[w_line_base + AW'(i)];
      end
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_store = (r_state == S_RESP) && r_store;
  assign bus.resp_data  = ((r_state == S_RESP) && !r_store) ? r_line : '0;

  a_wait_exit: assert property (@(posedge clk) disable iff (!reset_n)
    (r_state == S_WAIT) |=> (r_state inside {S_WAIT, S_RESP}));
  a_resp_exit: assert property (@(posedge clk) disable iff (!reset_n)
    (r_state == S_RESP) |=> (r_state == S_IDLE));
  a_resp_pulse: assert property (@(posedge clk) disable iff (!reset_n)
    bus.resp_valid |=> !bus.resp_valid);
endmodule
